// File: rtl/proc_ras_predictor.sv
// rtl/proc_ras_predictor.sv - return-address stack predicting jr targets
// Circular buffer; on overflow the oldest entry is overwritten and only count saturates.
module proc_ras_predictor #(
  parameter int p_depth      = 4,
  parameter int p_addr_nbits = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_val,
  input  logic [p_addr_nbits-1:0]    push_addr,
  input  logic                       pop_val,
  input  logic                       flush,
  output logic                       pred_val,
  output logic [p_addr_nbits-1:0]    pred_addr,
  output logic [$clog2(p_depth):0]   count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int c_ptr_nbits = $clog2(p_depth);
  localparam int c_cnt_nbits = c_ptr_nbits + 1;
  localparam logic [c_cnt_nbits-1:0] c_full = c_cnt_nbits'(p_depth);

  logic [p_addr_nbits-1:0] entries [p_depth];
  logic [c_ptr_nbits-1:0]  tos_r, tos_next;
  logic [c_cnt_nbits-1:0]  count_r, count_next;
  logic                    overflow_r, overflow_next;
  logic                    underflow_r, underflow_next;
  logic                    wr_en;
  logic [c_ptr_nbits-1:0]  wr_idx;
  logic                    empty;

  assign empty = (count_r == '0);

  always_comb begin
    tos_next       = tos_r;
    count_next     = count_r;
    overflow_next  = 1'b0;
    underflow_next = 1'b0;
    wr_en          = 1'b0;
    wr_idx         = tos_r;
    if (flush) begin
      count_next = '0;
    end else if (push_val && pop_val) begin
      // Pop-then-push on a non-empty stack just replaces the top entry.
      wr_en = 1'b1;
      if (empty) begin
        tos_next   = tos_r + 1'b1;
        wr_idx     = tos_r + 1'b1;
        count_next = c_cnt_nbits'(1);
      end
    end else if (push_val) begin
      wr_en    = 1'b1;
      tos_next = tos_r + 1'b1;
      wr_idx   = tos_r + 1'b1;
      if (count_r == c_full) begin
        overflow_next = 1'b1;
      end else begin
        count_next = count_r + 1'b1;
      end
    end else if (pop_val) begin
      if (empty) begin
        underflow_next = 1'b1;
      end else begin
        tos_next   = tos_r - 1'b1;
        count_next = count_r - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tos_r       <= '0;
      count_r     <= '0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      tos_r       <= tos_next;
      count_r     <= count_next;
      overflow_r  <= overflow_next;
      underflow_r <= underflow_next;
    end
  end

  // Entry storage is deliberately not reset; count gates every read.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      entries[wr_idx] <= push_addr;
    end
  end

  assign pred_val  = !empty;
  assign pred_addr = empty ? '0 : entries[tos_r];
  assign count     = count_r;
  assign overflow  = overflow_r;
  assign underflow = underflow_r;

endmodule

// File: tb/tb_proc_ras_predictor.sv
// tb/tb_proc_ras_predictor.sv - bench for proc_ras_predictor at depths 4, 2 and 8
// Shared stimulus drives three instances; each is checked against a shifting-array stack model.
module tb_proc_ras_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        push_val;
  logic [31:0] push_addr;
  logic        pop_val;
  logic        flush;

  logic        pv4, pv2, pv8;
  logic [31:0] pa4, pa2, pa8;
  logic [2:0]  cnt4;
  logic [1:0]  cnt2;
  logic [3:0]  cnt8;
  logic        ov4, ov2, ov8, un4, un2, un8;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  int          dep [3] = '{4, 2, 8};
  logic [31:0] ms  [3][8];
  int          msz [3];
  logic        mov [3];
  logic        mun [3];

  always #5 clk = ~clk;

  proc_ras_predictor #(.p_depth(4), .p_addr_nbits(32)) dut4 (
    .clk(clk), .rst(rst), .push_val(push_val), .push_addr(push_addr), .pop_val(pop_val),
    .flush(flush), .pred_val(pv4), .pred_addr(pa4), .count(cnt4), .overflow(ov4), .underflow(un4));

  proc_ras_predictor #(.p_depth(2), .p_addr_nbits(32)) dut2 (
    .clk(clk), .rst(rst), .push_val(push_val), .push_addr(push_addr), .pop_val(pop_val),
    .flush(flush), .pred_val(pv2), .pred_addr(pa2), .count(cnt2), .overflow(ov2), .underflow(un2));

  proc_ras_predictor #(.p_depth(8), .p_addr_nbits(32)) dut8 (
    .clk(clk), .rst(rst), .push_val(push_val), .push_addr(push_addr), .pop_val(pop_val),
    .flush(flush), .pred_val(pv8), .pred_addr(pa8), .count(cnt8), .overflow(ov8), .underflow(un8));

  task automatic model_update(input logic r, input logic f, input logic pu,
                              input logic [31:0] a, input logic po);
    for (int i = 0; i < 3; i++) begin
      mov[i] = 1'b0;
      mun[i] = 1'b0;
      if (r || f) begin
        msz[i] = 0;
      end else if (pu && po) begin
        if (msz[i] > 0) ms[i][msz[i]-1] = a;
        else begin
          ms[i][0] = a;
          msz[i]   = 1;
        end
      end else if (pu) begin
        if (msz[i] == dep[i]) begin
          for (int k = 0; k < dep[i] - 1; k++) ms[i][k] = ms[i][k+1];
          ms[i][dep[i]-1] = a;
          mov[i] = 1'b1;
        end else begin
          ms[i][msz[i]] = a;
          msz[i]++;
        end
      end else if (po) begin
        if (msz[i] > 0) msz[i]--;
        else mun[i] = 1'b1;
      end
    end
  endtask

  task automatic check_inst(input int i, input logic pv, input logic [31:0] pa,
                            input int cnt, input logic ov, input logic un);
    logic [31:0] exp_pa;
    exp_pa = (msz[i] > 0) ? ms[i][msz[i]-1] : 32'h0;
    n_checks += 5;
    if (pv !== (msz[i] != 0)) begin
      n_fail++;
      $display("FAIL d%0d pred_val: got %0b want %0b", dep[i], pv, msz[i] != 0);
    end
    if (pa !== exp_pa) begin
      n_fail++;
      $display("FAIL d%0d pred_addr: got %h want %h", dep[i], pa, exp_pa);
    end
    if (cnt != msz[i]) begin
      n_fail++;
      $display("FAIL d%0d count: got %0d want %0d", dep[i], cnt, msz[i]);
    end
    if (ov !== mov[i]) begin
      n_fail++;
      $display("FAIL d%0d overflow: got %0b want %0b", dep[i], ov, mov[i]);
    end
    if (un !== mun[i]) begin
      n_fail++;
      $display("FAIL d%0d underflow: got %0b want %0b", dep[i], un, mun[i]);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      check_inst(0, pv4, pa4, int'(cnt4), ov4, un4);
      check_inst(1, pv2, pa2, int'(cnt2), ov2, un2);
      check_inst(2, pv8, pa8, int'(cnt8), ov8, un8);
    end
  end

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic f, input logic pu,
                      input logic [31:0] a, input logic po);
    rst = r; flush = f; push_val = pu; push_addr = a; pop_val = po;
    @(posedge clk);
    #1;
    model_update(r, f, pu, a, po);
    rst = 1'b0; flush = 1'b0; push_val = 1'b0; pop_val = 1'b0;
  endtask

  task automatic do_rst();  step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0); endtask
  task automatic push(input logic [31:0] a); step(1'b0, 1'b0, 1'b1, a, 1'b0); endtask
  task automatic pop();     step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1); endtask
  task automatic idle();    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0); endtask

  initial begin
    rst = 1'b1; flush = 1'b0; push_val = 1'b0; pop_val = 1'b0; push_addr = '0;
    for (int i = 0; i < 3; i++) begin
      msz[i] = 0; mov[i] = 1'b0; mun[i] = 1'b0;
    end
    do_rst();
    check_en = 1'b1;
    lit("reset count", 32'(cnt4), 32'd0);
    lit("reset pred_val", 32'(pv4), 32'd0);
    lit("reset pred_addr", pa4, 32'h0);

    push(32'h100); push(32'h200); push(32'h300);
    lit("t1 count", 32'(cnt4), 32'd3);
    lit("t1 top", pa4, 32'h300);
    pop();  lit("t1 pop1", pa4, 32'h200);
    pop();  lit("t1 pop2", pa4, 32'h100);
    pop();  lit("t1 empty val", 32'(pv4), 32'd0);
    lit("t1 empty addr", pa4, 32'h0);

    do_rst();
    push(32'h10); push(32'h20); push(32'h30); push(32'h40);
    lit("t2 no ovf yet", 32'(ov4), 32'd0);
    push(32'h50);
    lit("t2 ovf", 32'(ov4), 32'd1);
    lit("t2 count", 32'(cnt4), 32'd4);
    lit("t2 top", pa4, 32'h50);
    idle(); lit("t2 ovf pulse end", 32'(ov4), 32'd0);
    pop(); lit("t2 pop1", pa4, 32'h40);
    pop(); lit("t2 pop2", pa4, 32'h30);
    pop(); lit("t2 pop3", pa4, 32'h20);
    pop(); lit("t2 pop4 val", 32'(pv4), 32'd0);

    pop();
    lit("t3 unf", 32'(un4), 32'd1);
    lit("t3 count", 32'(cnt4), 32'd0);
    push(32'hA0);
    lit("t3 unf end", 32'(un4), 32'd0);
    lit("t3 top", pa4, 32'hA0);

    do_rst();
    push(32'h100); push(32'h200);
    step(1'b0, 1'b0, 1'b1, 32'h300, 1'b1);
    lit("t4 count", 32'(cnt4), 32'd2);
    lit("t4 top", pa4, 32'h300);
    pop(); lit("t4 pop", pa4, 32'h100);
    do_rst();
    step(1'b0, 1'b0, 1'b1, 32'h44, 1'b1);
    lit("t4 empty count", 32'(cnt4), 32'd1);
    lit("t4 empty top", pa4, 32'h44);
    lit("t4 empty unf", 32'(un4), 32'd0);

    push(32'h1); push(32'h2); push(32'h3);
    step(1'b0, 1'b1, 1'b1, 32'h999, 1'b0);
    lit("t5 count", 32'(cnt4), 32'd0);
    lit("t5 val", 32'(pv4), 32'd0);
    push(32'h80);
    lit("t5 top", pa4, 32'h80);
    lit("t5 count1", 32'(cnt4), 32'd1);

    do_rst();
    push(32'h123);
    step(1'b1, 1'b0, 1'b1, 32'h456, 1'b0);
    lit("t6 count", 32'(cnt4), 32'd0);
    lit("t6 val", 32'(pv4), 32'd0);
    lit("t6 ovf", 32'(ov4), 32'd0);
    lit("t6 unf", 32'(un4), 32'd0);
    push(32'h1); push(32'h2); push(32'h3); push(32'h4); push(32'h5);
    do_rst();
    lit("t6 ovf cleared", 32'(ov4), 32'd0);

    for (int n = 0; n < 3000; n++) begin
      step(($urandom % 64) == 0, ($urandom % 20) == 0, ($urandom % 100) < 50,
           $urandom, ($urandom % 100) < 45);
    end
    idle();

    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
